// File: rtl/pipelined_ripple_adder_pkg.sv
// Shared definitions for the pipelined ripple add/subtract unit: mode encoding
// and the chunk geometry derived from WIDTH and STAGES.
package pipelined_ripple_adder_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  // Mode bit as presented on in_sub.
  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // Bits rippled by each pipeline stage.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Legal geometry: at least one stage, no more stages than bits, even split.
  function automatic bit geometry_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_ripple_adder_fa_cell.sv
// Single-bit full adder built from two half adders and an OR of their carries.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;
  logic g_ab;
  logic g_pc;

  assign p    = a ^ b;
  assign g_ab = a & b;
  assign s    = p ^ cin;
  assign g_pc = p & cin;
  assign cout = g_ab | g_pc;

endmodule

// File: rtl/pipelined_ripple_adder.sv
// WIDTH-bit add/subtract unit split into STAGES registered ripple chunks, with
// operand skew and result de-skew so every beat leaves in one piece.
module pipelined_ripple_adder
  import pipelined_ripple_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("pipelined_ripple_adder: STAGES must divide WIDTH and satisfy 1 <= STAGES <= WIDTH");
  end

  logic              adv;
  logic [STAGES-1:0] valid_reg;
  logic [STAGES-1:0] carry_reg;
  logic [STAGES-1:0] carry_next;
  logic [STAGES-1:0] chunk_cin;
  logic              ovf_reg;
  logic              ovf_next;
  logic              c0;
  logic [WIDTH-1:0]  b_eff;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH-1:0]  sum_w;
  logic [WIDTH-1:0]  res_w;

  // The whole pipe moves as one: it stalls only when a finished beat is refused.
  assign adv      = !valid_reg[STAGES-1] | out_ready;
  assign in_ready = adv;

  // Subtraction is A + ~B + 1; the inversion happens on entry so the mode
  // never needs to be carried down the pipe explicitly.
  assign b_eff = (mode_e'(in_sub) == MODE_SUB) ? ~in_b : in_b;
  assign c0    = (mode_e'(in_sub) == MODE_SUB) ? 1'b1 : in_cin;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      carry_reg <= '0;
      ovf_reg   <= 1'b0;
    end else if (adv) begin
      valid_reg[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        valid_reg[k] <= valid_reg[k-1];
      end
      carry_reg <= carry_next;
      ovf_reg   <= ovf_next;
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_chunk
    localparam int LO     = gi * CHUNK;
    localparam int DESKEW = STAGES - gi;

    logic [CHUNK-1:0] res_pipe [DESKEW];

    if (gi == 0) begin : g_direct
      assign op_a[LO +: CHUNK] = in_a[LO +: CHUNK];
      assign op_b[LO +: CHUNK] = b_eff[LO +: CHUNK];
      assign chunk_cin[gi]     = c0;
    end else begin : g_skew
      // Chunk gi waits gi cycles so it meets the carry of its own beat.
      logic [CHUNK-1:0] a_skew [gi];
      logic [CHUNK-1:0] b_skew [gi];

      always_ff @(posedge clk) begin
        if (adv) begin
          a_skew[0] <= in_a[LO +: CHUNK];
          b_skew[0] <= b_eff[LO +: CHUNK];
          for (int j = 1; j < gi; j++) begin
            a_skew[j] <= a_skew[j-1];
            b_skew[j] <= b_skew[j-1];
          end
        end
      end

      assign op_a[LO +: CHUNK] = a_skew[gi-1];
      assign op_b[LO +: CHUNK] = b_skew[gi-1];
      assign chunk_cin[gi]     = carry_reg[gi-1];
    end

    // Finished chunk gi is held back until the last chunk of its beat is done.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < DESKEW; j++) begin
          res_pipe[j] <= '0;
        end
      end else if (adv) begin
        res_pipe[0] <= sum_w[LO +: CHUNK];
        for (int j = 1; j < DESKEW; j++) begin
          res_pipe[j] <= res_pipe[j-1];
        end
      end
    end

    assign res_w[LO +: CHUNK] = res_pipe[DESKEW-1];
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic ci;
    logic co;

    if ((gi % CHUNK) == 0) begin : g_chunk_start
      assign ci = chunk_cin[gi / CHUNK];
    end else begin : g_ripple
      assign ci = g_bit[gi-1].co;
    end

    fa_cell u_fa (
      .a    (op_a[gi]),
      .b    (op_b[gi]),
      .cin  (ci),
      .s    (sum_w[gi]),
      .cout (co)
    );

    if ((gi % CHUNK) == (CHUNK - 1)) begin : g_chunk_end
      assign carry_next[gi / CHUNK] = co;
    end
  end

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign ovf_next = g_bit[WIDTH-1].ci ^ g_bit[WIDTH-1].co;

  assign out_valid = valid_reg[STAGES-1];
  assign out_sum   = res_w;
  assign out_cout  = carry_reg[STAGES-1];
  assign out_ovf   = ovf_reg;

endmodule
